// File: rtl/rob_mc.sv
// rob_mc: circular reorder buffer with NUM_WB writeback ports, up to COMMIT_W in-order
// retirements per cycle, and registered flush/resume redirects from BR/JALR retirement.

module rob_mc_sq #(
    parameter int IDX_W    = 4,
    parameter int NUM_WB   = 2,
    parameter int COMMIT_W = 2
) (
    input  logic [IDX_W-1:0]          id,
    input  logic [COMMIT_W-1:0]       cm_valid,
    input  logic [COMMIT_W*IDX_W-1:0] cm_id,
    input  logic [COMMIT_W*32-1:0]    cm_val,
    input  logic [NUM_WB-1:0]         wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]   wb_id,
    input  logic [NUM_WB*32-1:0]      wb_val,
    input  logic                      ent_rdy,
    input  logic [31:0]               ent_val,
    output logic                      rdy,
    output logic [31:0]               val
);
    logic hit;

    // First match wins: commit slots oldest-first, then writeback ports, then the entry.
    always_comb begin
        hit = 1'b0;
        val = ent_val;
        for (int c = 0; c < COMMIT_W; c++) begin
            if (!hit && cm_valid[c] && cm_id[c*IDX_W +: IDX_W] == id) begin
                hit = 1'b1;
                val = cm_val[c*32 +: 32];
            end
        end
        for (int p = 0; p < NUM_WB; p++) begin
            if (!hit && wb_valid[p] && wb_id[p*IDX_W +: IDX_W] == id) begin
                hit = 1'b1;
                val = wb_val[p*32 +: 32];
            end
        end
        rdy = hit || ent_rdy;
    end
endmodule

module rob_mc #(
    parameter int DEPTH    = 16,
    parameter int IDX_W    = 4,
    parameter int NUM_WB   = 2,
    parameter int COMMIT_W = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    output logic                      full,
    output logic [IDX_W:0]            count,
    input  logic                      iss_valid,
    input  logic [1:0]                iss_type,
    input  logic [4:0]                iss_rd,
    input  logic [31:0]               iss_aux,
    output logic [IDX_W-1:0]          iss_id,
    input  logic [NUM_WB-1:0]         wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]   wb_id,
    input  logic [NUM_WB*32-1:0]      wb_val,
    output logic                      st_head,
    input  logic                      st_done,
    output logic [COMMIT_W-1:0]       cm_valid,
    output logic [COMMIT_W*IDX_W-1:0] cm_id,
    output logic [COMMIT_W*5-1:0]     cm_rd,
    output logic [COMMIT_W*32-1:0]    cm_val,
    output logic                      flush,
    output logic                      resume,
    output logic [31:0]               redirect_pc,
    input  logic [IDX_W-1:0]          sq_id1,
    input  logic [IDX_W-1:0]          sq_id2,
    output logic                      sq_rdy1,
    output logic                      sq_rdy2,
    output logic [31:0]               sq_val1,
    output logic [31:0]               sq_val2
);
    localparam logic [1:0] T_BR = 2'd0, T_ST = 2'd1, T_JALR = 2'd2, T_RG = 2'd3;
    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0]        busy_q, done_q;
    logic [DEPTH-1:0][1:0]   type_q;
    logic [DEPTH-1:0][4:0]   rd_q;
    logic [DEPTH-1:0][31:0]  aux_q, val_q;
    logic [IDX_W-1:0]        head_q, tail_q;
    logic [IDX_W:0]          count_q;

    assign count   = count_q;
    assign full    = (count_q == DEPTH_C);
    assign iss_id  = tail_q;
    assign st_head = (count_q != '0) && (type_q[head_q] == T_ST) && done_q[head_q];

    logic                             iss_ok;
    logic [COMMIT_W-1:0]              ret;
    logic [COMMIT_W-1:0][IDX_W-1:0]   slot_idx;
    logic [IDX_W:0]                   n_ret;
    logic                             go, ctl_seen, do_flush, do_resume;
    logic [31:0]                      redir_nxt;

    assign iss_ok = iss_valid && !full;

    // In-order scan from head; a retiring BR/JALR ends the scan so the redirect is unambiguous.
    always_comb begin
        go        = 1'b1;
        ctl_seen  = 1'b0;
        ret       = '0;
        n_ret     = '0;
        do_flush  = 1'b0;
        do_resume = 1'b0;
        redir_nxt = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            slot_idx[k] = head_q + IDX_W'(k);
            if (go && !ctl_seen && ((IDX_W+1)'(k) < count_q) &&
                busy_q[slot_idx[k]] && done_q[slot_idx[k]] &&
                (type_q[slot_idx[k]] != T_ST || (k == 0 && st_done))) begin
                ret[k] = 1'b1;
                n_ret  = n_ret + (IDX_W+1)'(1);
                if (type_q[slot_idx[k]] == T_BR) begin
                    ctl_seen = 1'b1;
                    if (val_q[slot_idx[k]] != aux_q[slot_idx[k]]) begin
                        do_flush  = 1'b1;
                        redir_nxt = val_q[slot_idx[k]];
                    end
                end else if (type_q[slot_idx[k]] == T_JALR) begin
                    ctl_seen  = 1'b1;
                    do_resume = 1'b1;
                    redir_nxt = val_q[slot_idx[k]];
                end
            end else begin
                go = 1'b0;
            end
        end
    end

    // A registered flush acts as a reset on the following ready edge.
    always_ff @(posedge clk_in) begin
        if (rst_in || (flush && rdy_in)) begin
            busy_q      <= '0;
            done_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            cm_valid    <= '0;
            cm_id       <= '0;
            cm_rd       <= '0;
            cm_val      <= '0;
            flush       <= 1'b0;
            resume      <= 1'b0;
            redirect_pc <= '0;
        end else if (rdy_in) begin
            if (iss_ok) begin
                busy_q[tail_q] <= 1'b1;
                done_q[tail_q] <= 1'b0;
                type_q[tail_q] <= iss_type;
                rd_q[tail_q]   <= iss_rd;
                aux_q[tail_q]  <= iss_aux;
                val_q[tail_q]  <= '0;
                tail_q         <= tail_q + IDX_W'(1);
            end
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p]) begin
                    done_q[wb_id[p*IDX_W +: IDX_W]] <= 1'b1;
                    val_q[wb_id[p*IDX_W +: IDX_W]]  <= wb_val[p*32 +: 32];
                end
            end
            for (int k = 0; k < COMMIT_W; k++) begin
                if (ret[k]) begin
                    busy_q[slot_idx[k]] <= 1'b0;
                    done_q[slot_idx[k]] <= 1'b0;
                end
                cm_valid[k]              <= ret[k] && (type_q[slot_idx[k]] == T_RG ||
                                                       type_q[slot_idx[k]] == T_JALR);
                cm_id[k*IDX_W +: IDX_W]  <= slot_idx[k];
                cm_rd[k*5 +: 5]          <= rd_q[slot_idx[k]];
                cm_val[k*32 +: 32]       <= (type_q[slot_idx[k]] == T_JALR) ?
                                            aux_q[slot_idx[k]] : val_q[slot_idx[k]];
            end
            head_q      <= head_q + n_ret[IDX_W-1:0];
            count_q     <= count_q + (IDX_W+1)'(iss_ok) - n_ret;
            flush       <= do_flush;
            resume      <= do_resume;
            redirect_pc <= redir_nxt;
        end
    end

    logic [1:0][IDX_W-1:0] sq_id_a;
    logic [1:0]            sq_rdy_a;
    logic [1:0][31:0]      sq_val_a;

    assign sq_id_a = {sq_id2, sq_id1};

    for (genvar g = 0; g < 2; g++) begin : g_sq
        rob_mc_sq #(.IDX_W(IDX_W), .NUM_WB(NUM_WB), .COMMIT_W(COMMIT_W)) u_sq (
            .id       (sq_id_a[g]),
            .cm_valid (cm_valid),
            .cm_id    (cm_id),
            .cm_val   (cm_val),
            .wb_valid (wb_valid),
            .wb_id    (wb_id),
            .wb_val   (wb_val),
            .ent_rdy  (busy_q[sq_id_a[g]] && done_q[sq_id_a[g]]),
            .ent_val  (val_q[sq_id_a[g]]),
            .rdy      (sq_rdy_a[g]),
            .val      (sq_val_a[g])
        );
    end

    assign sq_rdy1 = sq_rdy_a[0];
    assign sq_rdy2 = sq_rdy_a[1];
    assign sq_val1 = sq_val_a[0];
    assign sq_val2 = sq_val_a[1];
endmodule

// File: tb/tb_rob_mc.sv
// Directed bench for rob_mc: commit, full/wrap, mispredict flush, JALR resume, store gating,
// search bypass and rdy_in freeze, each checked against hand-computed values.

module tb_rob_mc;
    localparam logic [1:0] BR = 2'd0, ST = 2'd1, JALR = 2'd2, RG = 2'd3;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, full, iss_valid, st_head, st_done, flush, resume;
    logic        sq_rdy1, sq_rdy2;
    logic [4:0]  count, iss_rd;
    logic [1:0]  iss_type, wb_valid, cm_valid;
    logic [31:0] iss_aux, redirect_pc, sq_val1, sq_val2;
    logic [3:0]  iss_id, sq_id1, sq_id2;
    logic [7:0]  wb_id, cm_id;
    logic [63:0] wb_val, cm_val;
    logic [9:0]  cm_rd;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_in = ~clk_in;

    rob_mc #(.DEPTH(16), .IDX_W(4), .NUM_WB(2), .COMMIT_W(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .full(full), .count(count),
        .iss_valid(iss_valid), .iss_type(iss_type), .iss_rd(iss_rd), .iss_aux(iss_aux),
        .iss_id(iss_id), .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val),
        .st_head(st_head), .st_done(st_done), .cm_valid(cm_valid), .cm_id(cm_id),
        .cm_rd(cm_rd), .cm_val(cm_val), .flush(flush), .resume(resume),
        .redirect_pc(redirect_pc), .sq_id1(sq_id1), .sq_id2(sq_id2),
        .sq_rdy1(sq_rdy1), .sq_rdy2(sq_rdy2), .sq_val1(sq_val1), .sq_val2(sq_val2)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1; rdy_in = 1'b1; iss_valid = 1'b0; iss_type = RG; iss_rd = '0;
        iss_aux = '0; wb_valid = '0; wb_id = '0; wb_val = '0; st_done = 1'b0;
        sq_id1 = '0; sq_id2 = '0;
        tick();
        rst_in = 1'b0;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] aux);
        iss_valid = 1'b1; iss_type = t; iss_rd = rd; iss_aux = aux;
        tick();
        iss_valid = 1'b0;
    endtask

    task automatic set_wb(input int p, input logic [3:0] id, input logic [31:0] v);
        wb_valid[p] = 1'b1;
        wb_id[p*4 +: 4] = id;
        wb_val[p*32 +: 32] = v;
    endtask

    task automatic test_reset();
        do_reset();
        issue(RG, 5'd1, 32'h0);
        issue(RG, 5'd2, 32'h0);
        n_vec++; if (count !== 5'd2) begin n_bad++; $display("FAIL pre_reset_count got %0d want 2", count); end
        rdy_in = 1'b0; rst_in = 1'b1;
        tick();
        rst_in = 1'b0; rdy_in = 1'b1;
        n_vec++; if (count !== 5'd0 || full !== 1'b0 || iss_id !== 4'd0)
            begin n_bad++; $display("FAIL reset_ptrs got count=%0d full=%b id=%0d want 0/0/0", count, full, iss_id); end
        n_vec++; if ({st_head, cm_valid, flush, resume} !== 5'b0 || redirect_pc !== 32'h0)
            begin n_bad++; $display("FAIL reset_outs got st=%b cmv=%b fl=%b rs=%b pc=%h want 0", st_head, cm_valid, flush, resume, redirect_pc); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(RG, 5'd1, 32'h0);
        issue(RG, 5'd2, 32'h0);
        set_wb(0, 4'd0, 32'h11); set_wb(1, 4'd1, 32'h22);
        tick();
        wb_valid = '0;
        n_vec++; if (count !== 5'd2 || cm_valid !== 2'b00)
            begin n_bad++; $display("FAIL b2b_wb_edge got count=%0d cmv=%b want 2/00", count, cm_valid); end
        tick();
        n_vec++; if (cm_valid !== 2'b11) begin n_bad++; $display("FAIL b2b_cm_valid got %b want 11", cm_valid); end
        n_vec++; if (cm_rd !== {5'd2, 5'd1} || cm_id !== {4'd1, 4'd0})
            begin n_bad++; $display("FAIL b2b_rd_id got rd=%h id=%h want 041/10", cm_rd, cm_id); end
        n_vec++; if (cm_val !== {32'h22, 32'h11}) begin n_bad++; $display("FAIL b2b_val got %h want 22/11", cm_val); end
        n_vec++; if (count !== 5'd0) begin n_bad++; $display("FAIL b2b_count got %0d want 0", count); end
        tick();
        n_vec++; if (cm_valid !== 2'b00) begin n_bad++; $display("FAIL b2b_pulse got %b want 00", cm_valid); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                n_vec++; if (iss_id !== 4'd15) begin n_bad++; $display("FAIL wrap_id15 got %0d want 15", iss_id); end
            end
            issue(RG, 5'(i + 1), 32'h0);
        end
        n_vec++; if (full !== 1'b1 || count !== 5'd16 || iss_id !== 4'd0)
            begin n_bad++; $display("FAIL full_state got full=%b count=%0d id=%0d want 1/16/0", full, count, iss_id); end
        issue(RG, 5'd31, 32'h0);
        n_vec++; if (count !== 5'd16 || iss_id !== 4'd0)
            begin n_bad++; $display("FAIL full_ignore got count=%0d id=%0d want 16/0", count, iss_id); end
        set_wb(0, 4'd0, 32'hA0); set_wb(1, 4'd1, 32'hA1);
        tick();
        wb_valid = '0;
        // Commit edge while full: the issue is judged on registered count and dropped.
        issue(RG, 5'd7, 32'h0);
        n_vec++; if (cm_valid !== 2'b11 || cm_val !== {32'hA1, 32'hA0})
            begin n_bad++; $display("FAIL full_commit got cmv=%b val=%h want 11/A1A0", cm_valid, cm_val); end
        n_vec++; if (count !== 5'd14 || iss_id !== 4'd0 || full !== 1'b0)
            begin n_bad++; $display("FAIL full_commit_cnt got count=%0d id=%0d full=%b want 14/0/0", count, iss_id, full); end
        issue(RG, 5'd8, 32'h0);
        n_vec++; if (count !== 5'd15 || iss_id !== 4'd1)
            begin n_bad++; $display("FAIL wrap_issue got count=%0d id=%0d want 15/1", count, iss_id); end
    endtask

    task automatic test_mispredict();
        do_reset();
        issue(BR, 5'd0, 32'h100);
        issue(RG, 5'd3, 32'h0);
        set_wb(0, 4'd0, 32'h200); set_wb(1, 4'd1, 32'h33);
        tick();
        wb_valid = '0;
        tick();
        n_vec++; if (flush !== 1'b1 || redirect_pc !== 32'h200 || resume !== 1'b0)
            begin n_bad++; $display("FAIL mp_flush got fl=%b pc=%h rs=%b want 1/200/0", flush, redirect_pc, resume); end
        n_vec++; if (cm_valid !== 2'b00 || count !== 5'd1)
            begin n_bad++; $display("FAIL mp_only_br got cmv=%b count=%0d want 00/1", cm_valid, count); end
        set_wb(0, 4'd2, 32'h55);
        issue(RG, 5'd9, 32'h0);
        wb_valid = '0;
        n_vec++; if (count !== 5'd0 || iss_id !== 4'd0 || cm_valid !== 2'b00 || flush !== 1'b0)
            begin n_bad++; $display("FAIL mp_clear got count=%0d id=%0d cmv=%b fl=%b want 0/0/00/0", count, iss_id, cm_valid, flush); end
        // Correctly predicted branch retires silently.
        issue(BR, 5'd0, 32'h100);
        set_wb(0, 4'd0, 32'h100);
        tick();
        wb_valid = '0;
        tick();
        n_vec++; if (flush !== 1'b0 || cm_valid !== 2'b00 || count !== 5'd0)
            begin n_bad++; $display("FAIL br_ok got fl=%b cmv=%b count=%0d want 0/00/0", flush, cm_valid, count); end
    endtask

    task automatic test_jalr();
        do_reset();
        issue(JALR, 5'd1, 32'h44);
        issue(RG, 5'd2, 32'h0);
        set_wb(0, 4'd0, 32'h80); set_wb(1, 4'd1, 32'h66);
        tick();
        wb_valid = '0;
        tick();
        n_vec++; if (cm_valid !== 2'b01 || cm_rd[4:0] !== 5'd1 || cm_val[31:0] !== 32'h44)
            begin n_bad++; $display("FAIL jalr_cm got cmv=%b rd=%0d val=%h want 01/1/44", cm_valid, cm_rd[4:0], cm_val[31:0]); end
        n_vec++; if (resume !== 1'b1 || redirect_pc !== 32'h80 || flush !== 1'b0 || count !== 5'd1)
            begin n_bad++; $display("FAIL jalr_resume got rs=%b pc=%h fl=%b count=%0d want 1/80/0/1", resume, redirect_pc, flush, count); end
        tick();
        n_vec++; if (resume !== 1'b0 || cm_valid !== 2'b01 || cm_rd[4:0] !== 5'd2 || cm_val[31:0] !== 32'h66)
            begin n_bad++; $display("FAIL jalr_next got rs=%b cmv=%b rd=%0d val=%h want 0/01/2/66", resume, cm_valid, cm_rd[4:0], cm_val[31:0]); end
    endtask

    task automatic test_store();
        do_reset();
        issue(ST, 5'd0, 32'h0);
        issue(RG, 5'd4, 32'h0);
        set_wb(0, 4'd0, 32'h5);
        tick();
        wb_valid = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (st_head !== 1'b1 || count !== 5'd2 || cm_valid !== 2'b00)
                begin n_bad++; $display("FAIL st_stall%0d got st=%b count=%0d cmv=%b want 1/2/00", i, st_head, count, cm_valid); end
        end
        st_done = 1'b1;
        set_wb(1, 4'd1, 32'h44);
        tick();
        st_done = 1'b0; wb_valid = '0;
        n_vec++; if (cm_valid !== 2'b00 || count !== 5'd1 || st_head !== 1'b0)
            begin n_bad++; $display("FAIL st_retire got cmv=%b count=%0d st=%b want 00/1/0", cm_valid, count, st_head); end
        tick();
        n_vec++; if (cm_valid !== 2'b01 || cm_rd[4:0] !== 5'd4 || cm_val[31:0] !== 32'h44 || count !== 5'd0)
            begin n_bad++; $display("FAIL st_follow got cmv=%b rd=%0d val=%h count=%0d want 01/4/44/0", cm_valid, cm_rd[4:0], cm_val[31:0], count); end
    endtask

    task automatic test_bypass_freeze();
        do_reset();
        for (int i = 0; i < 4; i++) issue(RG, 5'(i + 1), 32'h0);
        set_wb(1, 4'd3, 32'hAB);
        sq_id1 = 4'd3; sq_id2 = 4'd2;
        #1;
        n_vec++; if (sq_rdy1 !== 1'b1 || sq_val1 !== 32'hAB || sq_rdy2 !== 1'b0)
            begin n_bad++; $display("FAIL sq_wb_bypass got rdy1=%b val1=%h rdy2=%b want 1/AB/0", sq_rdy1, sq_val1, sq_rdy2); end
        tick();
        wb_valid = '0;
        #1;
        n_vec++; if (sq_rdy1 !== 1'b1 || sq_val1 !== 32'hAB)
            begin n_bad++; $display("FAIL sq_stored got rdy1=%b val1=%h want 1/AB", sq_rdy1, sq_val1); end
        set_wb(0, 4'd0, 32'h10);
        tick();
        wb_valid = '0;
        sq_id2 = 4'd0;
        tick();
        n_vec++; if (cm_valid !== 2'b01 || sq_rdy2 !== 1'b1 || sq_val2 !== 32'h10 || count !== 5'd3)
            begin n_bad++; $display("FAIL sq_cm_bypass got cmv=%b rdy2=%b val2=%h count=%0d want 01/1/10/3", cm_valid, sq_rdy2, sq_val2, count); end
        rdy_in = 1'b0;
        iss_valid = 1'b1; iss_type = RG; iss_rd = 5'd9;
        set_wb(0, 4'd1, 32'h99);
        tick();
        tick();
        iss_valid = 1'b0; wb_valid = '0;
        sq_id1 = 4'd1;
        #1;
        n_vec++; if (count !== 5'd3 || iss_id !== 4'd4 || cm_valid !== 2'b01 || sq_rdy1 !== 1'b0)
            begin n_bad++; $display("FAIL freeze got count=%0d id=%0d cmv=%b rdy1=%b want 3/4/01/0", count, iss_id, cm_valid, sq_rdy1); end
        rdy_in = 1'b1;
        tick();
        n_vec++; if (count !== 5'd3 || cm_valid !== 2'b00)
            begin n_bad++; $display("FAIL unfreeze got count=%0d cmv=%b want 3/00", count, cm_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_full_wrap();
        test_mispredict();
        test_jalr();
        test_store();
        test_bypass_freeze();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
